// File: rtl/rs_forney_eval.sv
// rs_forney_eval: Forney error-value evaluator for the Reed-Solomon decoder.
// Takes the error-locator polynomial, the error-evaluator polynomial and the
// Chien location list in one bundle. It then produces one error magnitude per
// location slot, one slot per cycle, and holds the result until it is taken.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input bundle handshake (lambda, omega, err_loc)
//   lambda               L0..LT, Li at [i*SYM_BW +: SYM_BW]
//   omega                W0..W(T-1), same packing
//   err_loc              location per slot, all-ones = empty slot
//   out_valid/out_ready  result handshake
//   err_val              error magnitude per slot
//   err_loc_out          slot locations forwarded from the input
//   err_cnt              number of non-empty slots
//   err_fail             at least one slot failed its check
module rs_forney_eval #(
  parameter int               SYM_BW    = 8,
  parameter int               T         = 4,
  parameter int               N_NUM     = 16,
  parameter logic [SYM_BW:0]  PRIM_POLY = 9'h11D,
  parameter int               FCR       = 1,
  parameter int               CNT_BW    = $clog2(T+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYM_BW*(T+1)-1:0] lambda,
  input  logic [SYM_BW*T-1:0]     omega,
  input  logic [SYM_BW*T-1:0]     err_loc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYM_BW*T-1:0]     err_val,
  output logic [SYM_BW*T-1:0]     err_loc_out,
  output logic [CNT_BW-1:0]       err_cnt,
  output logic                    err_fail
);

  typedef logic [SYM_BW-1:0] sym_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int   Q     = (1 << SYM_BW) - 1;
  localparam int   KW    = (T > 1) ? $clog2(T) : 1;
  localparam sym_t ONES  = '1;
  localparam sym_t ALPHA = sym_t'(2);
  // Exponent (1-FCR) mod (2^m-1), folded to a constant.
  localparam sym_t EXP_X = sym_t'((((1 - FCR) % Q) + Q) % Q);

  // Shift-and-add multiply with reduction by the primitive polynomial.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t r, s;
    r = '0;
    s = a;
    for (int i = 0; i < SYM_BW; i++) begin
      if (b[i]) r ^= s;
      s = {s[SYM_BW-2:0], 1'b0} ^ (s[SYM_BW-1] ? PRIM_POLY[SYM_BW-1:0] : '0);
    end
    return r;
  endfunction

  // Square-and-multiply exponentiation; e is any SYM_BW-bit exponent.
  function automatic sym_t gf_pow(input sym_t base, input sym_t e);
    sym_t r, b;
    r = sym_t'(1);
    b = base;
    for (int i = 0; i < SYM_BW; i++) begin
      if (e[i]) r = gf_mul(r, b);
      b = gf_mul(b, b);
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic   [KW-1:0]    k_q;
  sym_t   [T:0]       lam_q;
  sym_t   [T-1:0]     om_q, loc_q, val_acc, val_nxt;
  logic   [CNT_BW-1:0] cnt_acc, cnt_nxt;
  logic               fail_acc, fail_nxt;
  logic               last_slot;

  sym_t p, x, y, y2, l, d, w, slot_val;
  logic slot_fail, slot_cnt;

  assign last_slot = (k_q == KW'(T - 1));

  // Per-slot evaluation for the slot addressed by k_q.
  always_comb begin
    p         = loc_q[k_q];
    slot_val  = '0;
    slot_fail = 1'b0;
    slot_cnt  = 1'b0;
    // alpha^(2^m-1-p); for p=0 this is alpha^(2^m-1) = 1, same as alpha^0.
    y  = gf_pow(ALPHA, ONES - p);
    x  = gf_pow(ALPHA, p);
    y2 = gf_mul(y, y);
    l  = '0;
    for (int i = T; i >= 0; i--) l = gf_mul(l, y) ^ lam_q[i];
    w  = '0;
    for (int i = T - 1; i >= 0; i--) w = gf_mul(w, y) ^ om_q[i];
    // Formal derivative in characteristic 2 keeps only odd terms: Horner in Y^2.
    d  = '0;
    for (int i = T; i >= 1; i--)
      if ((i % 2) == 1) d = gf_mul(d, y2) ^ lam_q[i];
    if (p == ONES) begin
      slot_cnt = 1'b0;
    end else if (int'(p) >= N_NUM) begin
      slot_cnt  = 1'b1;
      slot_fail = 1'b1;
    end else begin
      slot_cnt = 1'b1;
      if (l != '0 || d == '0) slot_fail = 1'b1;
      else slot_val = gf_mul(gf_mul(gf_pow(x, EXP_X), w), gf_pow(d, ONES - sym_t'(1)));
    end
  end

  always_comb begin
    val_nxt      = val_acc;
    val_nxt[k_q] = slot_val;
    cnt_nxt      = cnt_acc + CNT_BW'(slot_cnt);
    fail_nxt     = fail_acc | slot_fail;
  end

  // FSM: next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_d = CALC;
      end
      CALC: if (last_slot) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q         <= '0;
      lam_q       <= '0;
      om_q        <= '0;
      loc_q       <= '1;
      val_acc     <= '0;
      cnt_acc     <= '0;
      fail_acc    <= 1'b0;
      err_val     <= '0;
      err_loc_out <= '1;
      err_cnt     <= '0;
      err_fail    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          lam_q    <= lambda;
          om_q     <= omega;
          loc_q    <= err_loc;
          val_acc  <= '0;
          cnt_acc  <= '0;
          fail_acc <= 1'b0;
          k_q      <= '0;
        end
        CALC: begin
          val_acc  <= val_nxt;
          cnt_acc  <= cnt_nxt;
          fail_acc <= fail_nxt;
          k_q      <= k_q + KW'(1);
          if (last_slot) begin
            err_val     <= val_nxt;
            err_loc_out <= loc_q;
            err_cnt     <= cnt_nxt;
            err_fail    <= fail_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_forney_eval.sv
// Self-checking bench for rs_forney_eval: directed cases, back-pressure, reset
// mid-operation, and random error patterns whose magnitudes are known.
module tb_rs_forney_eval;
  localparam int         SYM_BW = 8;
  localparam int         T      = 4;
  localparam int         N_NUM  = 16;
  localparam int         FCR    = 1;
  localparam int         CNT_BW = $clog2(T+1);
  localparam int         Q      = 255;
  localparam logic [8:0] PRIM   = 9'h11D;

  logic                    clk, rst, in_valid, in_ready, out_valid, out_ready, err_fail;
  logic [SYM_BW*(T+1)-1:0] lambda;
  logic [SYM_BW*T-1:0]     omega, err_loc, err_val, err_loc_out;
  logic [CNT_BW-1:0]       err_cnt;

  rs_forney_eval #(.SYM_BW(SYM_BW), .T(T), .N_NUM(N_NUM), .PRIM_POLY(PRIM),
                   .FCR(FCR), .CNT_BW(CNT_BW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lambda(lambda), .omega(omega), .err_loc(err_loc),
    .out_valid(out_valid), .out_ready(out_ready), .err_val(err_val),
    .err_loc_out(err_loc_out), .err_cnt(err_cnt), .err_fail(err_fail));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Log/antilog tables built from the primitive polynomial.
  int exp_t[0:Q-1];
  int log_t[0:Q];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % Q];
  endfunction

  function automatic int apow(input int e);
    return exp_t[((e % Q) + Q) % Q];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Current bundle and its expected result.
  int lam_a[T+1];
  int om_a[T];
  int loc_a[T];
  int ev[T];
  int e_cnt;
  int e_fail;

  logic [SYM_BW*(T+1)-1:0] p_lam;
  logic [SYM_BW*T-1:0]     p_om, p_loc, p_val;

  task automatic pack();
    for (int i = 0; i <= T; i++) p_lam[i*SYM_BW +: SYM_BW] = SYM_BW'(lam_a[i]);
    for (int i = 0; i < T; i++) begin
      p_om [i*SYM_BW +: SYM_BW] = SYM_BW'(om_a[i]);
      p_loc[i*SYM_BW +: SYM_BW] = SYM_BW'(loc_a[i]);
      p_val[i*SYM_BW +: SYM_BW] = SYM_BW'(ev[i]);
    end
  endtask

  task automatic send(input string tag);
    pack();
    @(negedge clk);
    lambda = p_lam; omega = p_om; err_loc = p_loc; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(T));
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_val"},   64'(err_val),     64'(p_val));
    chk({tag, "_loc"},   64'(err_loc_out), 64'(p_loc));
    chk({tag, "_cnt"},   64'(err_cnt),     64'(e_cnt));
    chk({tag, "_fail"},  64'(err_fail),    64'(e_fail));
    chk({tag, "_valid"}, 64'(out_valid),   64'd1);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_case(input string tag);
    send(tag);
    wait_out(tag);
    chk_out(tag);
    release_out(tag);
  endtask

  task automatic clear_case();
    lam_a = '{default:0};
    om_a  = '{default:0};
    loc_a = '{default:'hFF};
    ev    = '{default:0};
    e_cnt = 0;
    e_fail = 0;
  endtask

  task automatic set_case1();
    clear_case();
    lam_a[0] = 1; lam_a[1] = 1; om_a[0] = 'h5A; loc_a[0] = 0;
    ev[0] = 'h5A; e_cnt = 1;
  endtask

  // Random genuine error pattern: Lambda from the error locators, Omega from
  // the syndromes, so the expected magnitudes are the injected ones.
  task automatic rand_case();
    int nerr, p, X, r, idx, s;
    int pos[$];
    int mag[$];
    int slots[$];
    int S[2*T];
    bit dup;
    clear_case();
    lam_a[0] = 1;
    nerr = $urandom_range(1, T);
    while (pos.size() < nerr) begin
      p = $urandom_range(0, N_NUM-1);
      dup = 0;
      foreach (pos[i]) if (pos[i] == p) dup = 1;
      if (!dup) begin pos.push_back(p); mag.push_back($urandom_range(1, 255)); end
    end
    foreach (pos[i]) begin
      X = apow(pos[i]);
      for (int k = T; k >= 1; k--) lam_a[k] = lam_a[k] ^ gmul(X, lam_a[k-1]);
    end
    for (int j = 0; j < 2*T; j++) begin
      S[j] = 0;
      foreach (pos[i]) S[j] = S[j] ^ gmul(mag[i], apow((FCR + j) * pos[i]));
    end
    for (int k = 0; k < T; k++)
      for (int i = 0; i <= k; i++) om_a[k] = om_a[k] ^ gmul(S[i], lam_a[k-i]);
    for (int i = 0; i < T; i++) slots.push_back(i);
    foreach (pos[i]) begin
      idx = $urandom_range(0, slots.size()-1);
      s = slots[idx];
      slots.delete(idx);
      loc_a[s] = pos[i]; ev[s] = mag[i]; e_cnt++;
    end
    foreach (slots[i]) begin
      r = $urandom_range(0, 3);
      if (r == 2) begin
        do begin
          p = $urandom_range(0, N_NUM-1);
          dup = 0;
          foreach (pos[j]) if (pos[j] == p) dup = 1;
        end while (dup);
        loc_a[slots[i]] = p; e_cnt++; e_fail = 1;
      end else if (r == 3) begin
        loc_a[slots[i]] = $urandom_range(N_NUM, 254); e_cnt++; e_fail = 1;
      end
    end
  endtask

  initial begin
    int x;
    bit seen;
    x = 1;
    for (int i = 0; i < Q; i++) begin
      exp_t[i] = x; log_t[x] = i;
      x = x << 1;
      if (x & 256) x = x ^ int'(PRIM);
    end
    log_t[0] = 0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    lambda = '0; omega = '0; err_loc = '0;
    #2;
    chk("rst_in_ready",  64'(in_ready),    64'd0);
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_err_val",   64'(err_val),     64'd0);
    chk("rst_err_loc",   64'(err_loc_out), 64'hFFFF_FFFF);
    chk("rst_err_cnt",   64'(err_cnt),     64'd0);
    chk("rst_err_fail",  64'(err_fail),    64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    set_case1();
    run_case("case1");

    clear_case();
    lam_a[0] = 1; lam_a[1] = 2; om_a[0] = 2; loc_a[0] = 1; ev[0] = 1; e_cnt = 1;
    run_case("p1");

    set_case1();
    loc_a[0] = 3; ev[0] = 0; e_fail = 1;
    run_case("bad_root");

    set_case1();
    loc_a[0] = 'h10; ev[0] = 0; e_fail = 1;
    run_case("out_of_range");

    clear_case();
    lam_a[0] = 1; lam_a[1] = 1;
    run_case("all_empty");

    // Back-pressure: hold out_ready low, offer another bundle meanwhile.
    clear_case();
    lam_a[0] = 1; lam_a[1] = 2; om_a[0] = 2; loc_a[0] = 1; ev[0] = 1; e_cnt = 1;
    send("bp");
    wait_out("bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c == 1 || c == 2);
      lambda = '0; err_loc = '0;
      @(posedge clk);
      #1 chk_out("bp_hold");
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk) in_valid = 1'b0;
    release_out("bp");
    seen = 0;
    repeat (T + 2) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("bp_no_accept", 64'(seen), 64'd0);
    set_case1();
    run_case("bp_after");

    // Reset during the second CALC cycle.
    clear_case();
    lam_a[0] = 1; lam_a[1] = 2; om_a[0] = 2; loc_a[0] = 1;
    send("mid_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid),   64'd0);
    chk("mid_rst_err_val",   64'(err_val),     64'd0);
    chk("mid_rst_err_loc",   64'(err_loc_out), 64'hFFFF_FFFF);
    chk("mid_rst_err_cnt",   64'(err_cnt),     64'd0);
    chk("mid_rst_err_fail",  64'(err_fail),    64'd0);
    chk("mid_rst_in_ready",  64'(in_ready),    64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("mid_rst_in_ready_after", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (T + 2) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("mid_rst_no_result", 64'(seen), 64'd0);
    set_case1();
    run_case("mid_rst_fresh");

    for (int n = 0; n < 24; n++) begin
      rand_case();
      run_case("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
